fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 125 ++++++++++++
 tb/tb_fifo_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered or first-word-fall-through read,
// occupancy count, programmable almost-full/almost-empty and sticky error flags.
module fifo_param #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDRESS_SIZE = 3,
    parameter int FWFT         = 0,
    parameter int AF_LEVEL     = (2**ADDRESS_SIZE) - 1,
    parameter int AE_LEVEL     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_SIZE-1:0]  data_in,
    output logic [DATA_SIZE-1:0]  data_out,
    output logic [ADDRESS_SIZE:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH   = 2**ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] C_DEPTH = {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE:0] C_AF    = AF_LEVEL[ADDRESS_SIZE:0];
    localparam logic [ADDRESS_SIZE:0] C_AE    = AE_LEVEL[ADDRESS_SIZE:0];

    logic [DATA_SIZE-1:0]    r_mem [DEPTH];
    logic [ADDRESS_SIZE-1:0] r_wr_ptr;
    logic [ADDRESS_SIZE-1:0] r_rd_ptr;
    logic [ADDRESS_SIZE:0]   r_count;
    logic [DATA_SIZE-1:0]    r_dout;
    logic                    r_ovf;
    logic                    r_unf;

    logic w_empty;
    logic w_pop_acc;
    logic w_push_acc;
    logic w_push_rej;
    logic w_pop_rej;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    always_comb begin
        w_empty    = (r_count == '0);
        w_pop_acc  = pop && !w_empty && !flush;
        w_push_acc = push && !flush && ((r_count != C_DEPTH) || w_pop_acc);
        w_push_rej = push && !flush && !w_push_acc;
        w_pop_rej  = pop && !flush && w_empty;
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Holds the last word popped; in FWFT mode this is the stable value shown while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_pop_acc) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (clr_err) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_rej) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_rej) begin
                r_unf <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = w_empty ? r_dout : r_mem[r_rd_ptr];
    end else begin : g_registered
        assign data_out = r_dout;
    end

    assign count        = r_count;
    assign full         = (r_count == C_DEPTH);
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: one registered-read and one FWFT instance share the same
// stimulus; a queue model predicts popped data, occupancy and sticky flags.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr_err;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic [3:0] cnt0, cnt1;
    logic full0, empty0, af0, ae0, ovf0, unf0;
    logic full1, empty1, af1, ae1, ovf1, unf1;

    logic [7:0] q[$];
    logic [7:0] exp_dout0;
    logic       exp_ovf;
    logic       exp_unf;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_SIZE(8), .ADDRESS_SIZE(3), .FWFT(0), .AF_LEVEL(7), .AE_LEVEL(1)) dut_reg (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(dout0), .count(cnt0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_param #(.DATA_SIZE(8), .ADDRESS_SIZE(3), .FWFT(1), .AF_LEVEL(7), .AE_LEVEL(1)) dut_fwft (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(dout1), .count(cnt1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
    );

    // One clock of stimulus; the model predicts the cycle and the scoreboard compares.
    task automatic step(input logic p, input logic r, input logic [7:0] d,
                        input logic f, input logic c);
        logic pa;
        logic ua;
        int   n;
        push = p; pop = r; data_in = d; flush = f; clr_err = c;
        n  = q.size();
        pa = r && (n > 0) && !f;
        ua = p && !f && ((n < 8) || pa);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (pa) exp_dout0 = q.pop_front();
            if (ua) q.push_back(d);
        end
        if (c) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (p && !f && !ua) exp_ovf = 1'b1;
            if (r && !f && !pa) exp_unf = 1'b1;
        end
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        checks++;
        if (cnt0 !== 4'(q.size()) || cnt1 !== 4'(q.size())) begin
            errors++;
            $display("FAIL sb_count: got %0d/%0d expected %0d", cnt0, cnt1, q.size());
        end
        checks++;
        if (dout0 !== exp_dout0) begin
            errors++;
            $display("FAIL sb_dout_reg: got %h expected %h", dout0, exp_dout0);
        end
        checks++;
        if (ovf0 !== exp_ovf || unf0 !== exp_unf || ovf1 !== exp_ovf || unf1 !== exp_unf) begin
            errors++;
            $display("FAIL sb_err_flags: got ovf=%b/%b unf=%b/%b expected ovf=%b unf=%b",
                     ovf0, ovf1, unf0, unf1, exp_ovf, exp_unf);
        end
        if (q.size() > 0) begin
            checks++;
            if (dout1 !== q[0]) begin
                errors++;
                $display("FAIL sb_fwft_head: got %h expected %h", dout1, q[0]);
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout0 = 8'h00;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100 || cnt0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags: got f/e/af/ae/ov/un=%b cnt=%0d expected 010100 cnt=0",
                     {full0, empty0, af0, ae0, ovf0, unf0}, cnt0);
        end
        checks++;
        if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h/%h expected 00/00", dout0, dout1);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            if (i == 0 || i == 1) begin
                checks++;
                if (ae0 !== (i == 0)) begin
                    errors++;
                    $display("FAIL almost_empty_level: got %b at count %0d", ae0, i + 1);
                end
            end
            if (i == 6) begin
                checks++;
                if (af0 !== 1'b1 || full0 !== 1'b0) begin
                    errors++;
                    $display("FAIL almost_full_7: got af=%b full=%b expected af=1 full=0", af0, full0);
                end
            end
        end
        checks++;
        if (full0 !== 1'b1 || cnt0 !== 4'd8) begin
            errors++;
            $display("FAIL full_8: got full=%b cnt=%0d expected 1/8", full0, cnt0);
        end
        step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (ovf0 !== 1'b1 || cnt0 !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b cnt=%0d expected 1/8", ovf0, cnt0);
        end
        // clr_err wins over a same-cycle rejected push
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        checks++;
        if (ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_err_priority: got ovf=%b expected 0", ovf0);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checks++;
            if (dout0 !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order: got %h expected %h", dout0, 8'(i));
            end
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (empty0 !== 1'b1 || unf0 !== 1'b1 || dout0 !== 8'h07) begin
            errors++;
            $display("FAIL underflow_hold: got e=%b unf=%b dout=%h expected 1/1/07", empty0, unf0, dout0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (cnt0 !== 4'd8 || ovf0 !== 1'b0 || dout0 !== 8'h00) begin
            errors++;
            $display("FAIL full_push_pop: got cnt=%0d ovf=%b dout=%h expected 8/0/00", cnt0, ovf0, dout0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checks++;
            if (dout0 !== ((i < 7) ? 8'(i + 1) : 8'hAA)) begin
                errors++;
                $display("FAIL full_push_pop_order: got %h at pop %0d", dout0, i);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        step(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
        checks++;
        if (cnt0 !== 4'd1 || unf0 !== 1'b1 || dout1 !== 8'h5C) begin
            errors++;
            $display("FAIL empty_push_pop: got cnt=%0d unf=%b head=%h expected 1/1/5c", cnt0, unf0, dout1);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        checks++;
        if (unf0 !== 1'b0 || dout0 !== 8'h5C) begin
            errors++;
            $display("FAIL empty_push_pop_read: got unf=%b dout=%h expected 0/5c", unf0, dout0);
        end
    endtask

    task automatic test_fwft();
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        checks++;
        if (dout1 !== 8'h11) begin
            errors++;
            $display("FAIL fwft_first: got %h expected 11", dout1);
        end
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout1 !== 8'h22 || dout0 !== 8'h11) begin
            errors++;
            $display("FAIL fwft_advance: got fwft=%h reg=%h expected 22/11", dout1, dout0);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h40 + 8'(k * 8 + i), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        checks++;
        if (cnt0 !== 4'd0 || empty0 !== 1'b1 || dout0 !== 8'h44) begin
            errors++;
            $display("FAIL flush: got cnt=%0d e=%b dout=%h expected 0/1/44", cnt0, empty0, dout0);
        end
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout0 !== 8'h77) begin
            errors++;
            $display("FAIL after_flush: got %h expected 77", dout0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (cnt0 !== 4'd4 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d ovf=%b expected 4/1", cnt0, ovf0);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100 || cnt0 !== 4'd0 ||
            {full1, empty1, af1, ae1, ovf1, unf1} !== 6'b010100 || cnt1 !== 4'd0 ||
            dout0 !== 8'h00 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got f/e/af/ae/ov/un=%b/%b cnt=%0d/%0d dout=%h/%h expected 010100 0 00",
                     {full0, empty0, af0, ae0, ovf0, unf0}, {full1, empty1, af1, ae1, ovf1, unf1},
                     cnt0, cnt1, dout0, dout1);
        end
        #2 rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 8'hAB, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dout0 !== 8'hAB) begin
            errors++;
            $display("FAIL post_reset_first: got %h expected ab", dout0);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (unf0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got ovf=%b unf=%b expected 0/0", ovf0, unf0);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_fwft();
        test_wrap_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
